// File: rtl/display_timings_480p.sv
// Pixel-position counters and sync/enable generation for a 640x480 display.
// All outputs are registered from the same next position so they stay aligned.
module display_timings_480p #(
  parameter int H_RES  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_RES  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic       clk_pix,
  input  logic       rst,
  input  logic       clk_pix_locked,
  output logic [9:0] sx,
  output logic [9:0] sy,
  output logic       hsync,
  output logic       vsync,
  output logic       de,
  output logic       line,
  output logic       frame
);

  localparam int H_T = H_RES + H_FP + H_SYNC + H_BP;
  localparam int V_T = V_RES + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_MAX = 10'(H_T - 1);
  localparam logic [9:0] V_MAX = 10'(V_T - 1);

  // 11-bit bounds so an end value of 1024 does not wrap
  localparam logic [10:0] H_ACT  = 11'(H_RES);
  localparam logic [10:0] V_ACT  = 11'(V_RES);
  localparam logic [10:0] HS_STA = 11'(H_RES + H_FP);
  localparam logic [10:0] HS_END = 11'(H_RES + H_FP + H_SYNC);
  localparam logic [10:0] VS_STA = 11'(V_RES + V_FP);
  localparam logic [10:0] VS_END = 11'(V_RES + V_FP + V_SYNC);

  logic [9:0]  sx_n;
  logic [9:0]  sy_n;
  logic [10:0] sx_w;
  logic [10:0] sy_w;
  logic        h_wrap;

  always_comb begin
    h_wrap = (sx == H_MAX);
    sx_n   = h_wrap ? 10'd0 : sx + 10'd1;
    sy_n   = sy;
    if (h_wrap) begin
      sy_n = (sy == V_MAX) ? 10'd0 : sy + 10'd1;
    end
    sx_w = {1'b0, sx_n};
    sy_w = {1'b0, sy_n};
  end

  always_ff @(posedge clk_pix or posedge rst) begin
    if (rst) begin
      sx    <= H_MAX;
      sy    <= V_MAX;
      hsync <= 1'b1;
      vsync <= 1'b1;
      de    <= 1'b0;
      line  <= 1'b0;
      frame <= 1'b0;
    end else if (clk_pix_locked) begin
      sx    <= sx_n;
      sy    <= sy_n;
      hsync <= ~((sx_w >= HS_STA) && (sx_w < HS_END));
      vsync <= ~((sy_w >= VS_STA) && (sy_w < VS_END));
      de    <= (sx_w < H_ACT) && (sy_w < V_ACT);
      line  <= (sx_n == 10'd0);
      frame <= (sx_n == 10'd0) && (sy_n == 10'd0);
    end else begin
      line  <= 1'b0;
      frame <= 1'b0;
    end
  end

endmodule

// File: doc/display_timings_480p.md
DISPLAY_TIMINGS_480P -- requirements
Module: display_timings_480p

Interface
REQ-001 The block SHALL have parameter H_RES, default 640, meaning active pixels per line.
REQ-002 The block SHALL have parameter H_FP, default 16, meaning horizontal front porch in pixel clocks.
REQ-003 The block SHALL have parameter H_SYNC, default 96, meaning hsync pulse width in pixel clocks.
REQ-004 The block SHALL have parameter H_BP, default 48, meaning horizontal back porch in pixel clocks.
REQ-005 The block SHALL have parameter V_RES, default 480, meaning active lines per frame.
REQ-006 The block SHALL have parameter V_FP, default 10, meaning vertical front porch in lines.
REQ-007 The block SHALL have parameter V_SYNC, default 2, meaning vsync pulse width in lines.
REQ-008 The block SHALL have parameter V_BP, default 33, meaning vertical back porch in lines.
REQ-009 The block SHALL have port clk_pix, input, 1 bit: the pixel clock; it is the only clock.
REQ-010 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-011 The block SHALL have port clk_pix_locked, input, 1 bit: pixel clock is stable; counting is enabled only while high.
REQ-012 The block SHALL have port sx, output, 10 bits: horizontal position, 0..H_T-1, where H_T = H_RES+H_FP+H_SYNC+H_BP.
REQ-013 The block SHALL have port sy, output, 10 bits: vertical position, 0..V_T-1, where V_T = V_RES+V_FP+V_SYNC+V_BP.
REQ-014 The block SHALL have port hsync, output, 1 bit: horizontal sync, active low.
REQ-015 The block SHALL have port vsync, output, 1 bit: vertical sync, active low.
REQ-016 The block SHALL have port de, output, 1 bit: data enable, high for active pixels.
REQ-017 The block SHALL have port line, output, 1 bit: one-cycle pulse at the start of each line.
REQ-018 The block SHALL have port frame, output, 1 bit: one-cycle pulse at the start of each frame.

Function
REQ-019 All outputs SHALL be registered on posedge clk_pix and SHALL be mutually consistent, i.e. describe the same (sx, sy) in the same cycle.
REQ-020 On an edge with clk_pix_locked high, sx SHALL increment by 1, and wrap H_T-1 -> 0.
REQ-021 On that wrap sy SHALL increment by 1, and wrap V_T-1 -> 0; sy SHALL NOT change on any other edge.
REQ-022 On an edge with clk_pix_locked low, sx, sy, hsync, vsync and de SHALL hold their values, and line and frame SHALL be 0.
REQ-023 de SHALL be 1 iff sx < H_RES and sy < V_RES.
REQ-024 hsync SHALL be 0 iff H_RES+H_FP <= sx < H_RES+H_FP+H_SYNC; otherwise 1.
REQ-025 vsync SHALL be 0 iff V_RES+V_FP <= sy < V_RES+V_FP+V_SYNC; otherwise 1; it is independent of sx.
REQ-026 line SHALL be 1 for exactly the cycle in which sx becomes 0 on an enabled edge.
REQ-027 frame SHALL be 1 for exactly the cycle in which sx and sy both become 0 on an enabled edge; frame implies line.
REQ-028 H_T and V_T SHALL each be <= 1024; with the defaults, H_T = 800, V_T = 525, and the frame period is 420000 enabled clocks.

Reset
REQ-029 While rst is high, regardless of clk_pix, the outputs SHALL be: sx = H_T-1, sy = V_T-1, hsync = 1, vsync = 1, de = 0, line = 0, frame = 0.
REQ-030 The first enabled edge after rst deasserts SHALL produce sx = 0, sy = 0, de = 1, line = 1, frame = 1.
REQ-031 Asserting rst mid-frame SHALL immediately force the REQ-029 values, with no partial line or pulse emitted.

Verification
REQ-032 Reset release with clk_pix_locked = 1 -> first edge: sx=0, sy=0, de=1, frame=1, line=1; next edge: sx=1, frame=0, line=0.
REQ-033 Run one line -> hsync low exactly for sx 656..751 (96 cycles); de high for sx 0..639; line pulses every 800 cycles.
REQ-034 Run two frames -> vsync low exactly for sy 490..491 (1600 cycles); frame pulses 420000 cycles apart; sy never exceeds 524.
REQ-035 Drop clk_pix_locked for 50 cycles at sx=700, sy=100 -> all positional outputs frozen, line=frame=0; on resume, sx=701.
REQ-036 Assert rst asynchronously at sx=320, sy=240 -> outputs take the reset values before the next clk_pix edge; after release, the first enabled edge gives frame=1.
